// File: rtl/speed_calc_if.sv
// Event/result bundle for speed_calc: entry/exit line crossings in, speed-memory writes out.
// The slave modport is the speed_calc side; master is the driver/consumer side.
interface speed_calc_if #(
    parameter int width = 8,
    parameter int depth = 6
);
    logic             i_tick;
    logic             i_entry_valid;
    logic [depth-1:0] i_entry_id;
    logic             i_exit_valid;
    logic [depth-1:0] i_exit_id;
    logic             o_exit_ready;
    logic [width-1:0] o_speed;
    logic [depth-1:0] o_addr_speed;
    logic             o_wen;
    logic             o_drop;

    modport slave (
        input  i_tick, i_entry_valid, i_entry_id, i_exit_valid, i_exit_id,
        output o_exit_ready, o_speed, o_addr_speed, o_wen, o_drop
    );

    modport master (
        output i_tick, i_entry_valid, i_entry_id, i_exit_valid, i_exit_id,
        input  o_exit_ready, o_speed, o_addr_speed, o_wen, o_drop
    );
endinterface

// File: rtl/speed_calc.sv
// Per-object transit timer: stamps entries, divides DIST_K by elapsed ticks on exit, writes speed.
// Optional macro SPEED_SAT_EN clamps the speed to 2**width-1 instead of truncating the quotient.
module speed_calc #(
    parameter int width  = 8,
    parameter int depth  = 6,
    parameter int TW     = 16,
    parameter int NW     = 24,
    parameter int DIST_K = 36000
) (
    input logic         clk,
    input logic         rst_n,
    speed_calc_if.slave bus
);
    localparam int              Entries  = 2 ** depth;
    localparam int              CntW     = $clog2(NW + 1);
    localparam logic [NW-1:0]   DistK    = NW'(DIST_K);
    localparam logic [CntW-1:0] LastStep = CntW'(NW - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    ts_q, ts_d;
    logic [Entries-1:0] valid_q, valid_d;
    logic [TW-1:0]    startTab_q [Entries];
    logic [TW-1:0]    divisor_q, divisor_d;
    logic [TW-1:0]    remain_q, remain_d;
    logic [NW-1:0]    quotient_q, quotient_d;
    logic [CntW-1:0]  step_q, step_d;
    logic [depth-1:0] id_q, id_d;
    logic [width-1:0] speed_q, speed_d;
    logic [depth-1:0] addr_q, addr_d;
    logic             wen_q, wen_d;
    logic             drop_q, drop_d;

    logic             accept;
    logic [TW-1:0]    elapsed;
    logic [TW:0]      remShift;
    logic             fits;
    logic [TW-1:0]    remSub;
    logic [width-1:0] speedResult;

    assign accept   = bus.i_exit_valid && (state_q == IDLE) && valid_q[bus.i_exit_id];
    assign elapsed  = ts_q - startTab_q[bus.i_exit_id];

    // Restoring step: the true difference is below the divisor, so TW bits suffice.
    assign remShift = {remain_q, quotient_q[NW-1]};
    assign fits     = remShift >= {1'b0, divisor_q};
    assign remSub   = remShift[TW-1:0] - divisor_q;

`ifdef SPEED_SAT_EN
    localparam logic [NW-1:0] SpeedMax = NW'((64'd1 << width) - 64'd1);
    assign speedResult = (quotient_q > SpeedMax) ? '1 : quotient_q[width-1:0];
`else
    assign speedResult = quotient_q[width-1:0];
`endif

    always_comb begin
        state_d    = state_q;
        ts_d       = ts_q + TW'(bus.i_tick);
        valid_d    = valid_q;
        divisor_d  = divisor_q;
        remain_d   = remain_q;
        quotient_d = quotient_q;
        step_d     = step_q;
        id_d       = id_q;
        speed_d    = speed_q;
        addr_d     = addr_q;
        wen_d      = 1'b0;
        drop_d     = bus.i_exit_valid && !accept;

        // Entry is applied after the exit clear so a same-cycle re-entry stays armed.
        if (accept) begin
            valid_d[bus.i_exit_id] = 1'b0;
        end
        if (bus.i_entry_valid) begin
            valid_d[bus.i_entry_id] = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    divisor_d  = (elapsed == '0) ? TW'(1) : elapsed;
                    remain_d   = '0;
                    quotient_d = DistK;
                    step_d     = '0;
                    id_d       = bus.i_exit_id;
                    state_d    = DIV;
                end
            end
            DIV: begin
                remain_d   = fits ? remSub : remShift[TW-1:0];
                quotient_d = {quotient_q[NW-2:0], fits};
                step_d     = step_q + CntW'(1);
                if (step_q == LastStep) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                wen_d   = 1'b1;
                speed_d = speedResult;
                addr_d  = id_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ts_q       <= '0;
            valid_q    <= '0;
            divisor_q  <= '0;
            remain_q   <= '0;
            quotient_q <= '0;
            step_q     <= '0;
            id_q       <= '0;
            speed_q    <= '0;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_d;
            valid_q    <= valid_d;
            divisor_q  <= divisor_d;
            remain_q   <= remain_d;
            quotient_q <= quotient_d;
            step_q     <= step_d;
            id_q       <= id_d;
            speed_q    <= speed_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            drop_q     <= drop_d;
        end
    end

    // Start stamps need no reset: a stamp is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (bus.i_entry_valid) begin
            startTab_q[bus.i_entry_id] <= ts_q;
        end
    end

    assign bus.o_exit_ready = (state_q == IDLE);
    assign bus.o_speed      = speed_q;
    assign bus.o_addr_speed = addr_q;
    assign bus.o_wen        = wen_q;
    assign bus.o_drop       = drop_q;
endmodule

// File: tb/tb_speed_calc.sv
// Directed bench for speed_calc: transit timing, wrap, zero elapsed, drops, busy exits, reset abort.
// Expected speeds are hand-computed from DIST_K=36000; SPEED_SAT_EN selects the clamped values.
module tb_speed_calc;
    localparam int W  = 8;
    localparam int D  = 6;
    localparam int TW = 16;
    localparam int NW = 24;

`ifdef SPEED_SAT_EN
    localparam int ExpSat100 = 255;
    localparam int ExpZero   = 255;
`else
    localparam int ExpSat100 = 104;
    localparam int ExpZero   = 160;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   testsRun = 0;
    int   testsFailed = 0;
    int   modelTs;

    always #5 clk = ~clk;

    speed_calc_if #(.width(W), .depth(D)) bus ();

    speed_calc #(
        .width(W), .depth(D), .TW(TW), .NW(NW), .DIST_K(36000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference timestamp, kept by the bench from its own tick stimulus.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) modelTs <= 0;
        else if (bus.i_tick) modelTs <= (modelTs + 1) % 65536;
    end

    task automatic waitTs(input int target);
        int n;
        n = 0;
        while (modelTs != target && n < 70000) begin
            @(negedge clk);
            n++;
        end
        if (modelTs != target) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL waitTs timeout: ts %0d, wanted %0d", modelTs, target);
        end
    endtask

    task automatic pulse(input logic ev, input int eid, input logic xv, input int xid);
        bus.i_entry_valid = ev;
        bus.i_entry_id    = D'(eid);
        bus.i_exit_valid  = xv;
        bus.i_exit_id     = D'(xid);
        @(negedge clk);
        bus.i_entry_valid = 1'b0;
        bus.i_exit_valid  = 1'b0;
    endtask

    task automatic waitWen(input int window, output int lat, output int cnt,
                           output int spd, output int adr, output int drops);
        lat = 0; cnt = 0; spd = -1; adr = -1; drops = 0;
        for (int k = 1; k <= window; k++) begin
            @(negedge clk);
            if (bus.o_wen) begin
                if (cnt == 0) begin
                    lat = k;
                    spd = int'(bus.o_speed);
                    adr = int'(bus.o_addr_speed);
                end
                cnt++;
            end
            if (bus.o_drop) drops++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        testsRun++;
        if (bus.o_wen !== 1'b0 || bus.o_drop !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_strobes: wen %b drop %b, required 0 0", bus.o_wen, bus.o_drop);
        end
        testsRun++;
        if (bus.o_speed !== 8'd0 || bus.o_addr_speed !== 6'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_data: speed %0d addr %0d, required 0 0", bus.o_speed, bus.o_addr_speed);
        end
        rst_n = 1'b1;
        @(negedge clk);
        testsRun++;
        if (bus.o_exit_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_ready: got %b, required 1", bus.o_exit_ready);
        end
    endtask

    task automatic test_basic();
        int lat, cnt, spd, adr, drops;
        waitTs(1000);
        pulse(1'b1, 5, 1'b0, 0);
        waitTs(1400);
        pulse(1'b0, 0, 1'b1, 5);
        testsRun++;
        if (bus.o_exit_ready !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL basic_busy_ready: got %b, required 0", bus.o_exit_ready);
        end
        waitWen(NW + 4, lat, cnt, spd, adr, drops);
        testsRun++;
        if (lat != NW + 1 || cnt != 1) begin
            testsFailed++;
            $display("[TB] FAIL basic_timing: latency %0d count %0d, required %0d 1", lat, cnt, NW + 1);
        end
        testsRun++;
        if (spd != 90 || adr != 5) begin
            testsFailed++;
            $display("[TB] FAIL basic_result: speed %0d addr %0d, required 90 5", spd, adr);
        end
        testsRun++;
        if (drops != 0) begin
            testsFailed++;
            $display("[TB] FAIL basic_nodrop: drops %0d, required 0", drops);
        end
        testsRun++;
        if (bus.o_speed !== 8'd90 || bus.o_addr_speed !== 6'd5 || bus.o_exit_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL basic_hold: speed %0d addr %0d ready %b, required 90 5 1",
                     bus.o_speed, bus.o_addr_speed, bus.o_exit_ready);
        end
    endtask

    task automatic test_zero_elapsed();
        int lat, cnt, spd, adr, drops;
        waitTs(2000);
        bus.i_tick = 1'b0;
        pulse(1'b1, 6, 1'b0, 0);
        pulse(1'b0, 0, 1'b1, 6);
        bus.i_tick = 1'b1;
        waitWen(NW + 4, lat, cnt, spd, adr, drops);
        testsRun++;
        if (cnt != 1 || spd != ExpZero || adr != 6) begin
            testsFailed++;
            $display("[TB] FAIL zero_elapsed: count %0d speed %0d addr %0d, required 1 %0d 6",
                     cnt, spd, adr, ExpZero);
        end
    endtask

    task automatic test_same_cycle();
        int lat, cnt, spd, adr, drops;
        waitTs(3000);
        pulse(1'b1, 12, 1'b0, 0);
        waitTs(3400);
        pulse(1'b1, 12, 1'b1, 12);
        waitWen(NW + 4, lat, cnt, spd, adr, drops);
        testsRun++;
        if (cnt != 1 || spd != 90 || adr != 12) begin
            testsFailed++;
            $display("[TB] FAIL same_cycle_old: count %0d speed %0d addr %0d, required 1 90 12", cnt, spd, adr);
        end
        waitTs(3600);
        pulse(1'b0, 0, 1'b1, 12);
        waitWen(NW + 4, lat, cnt, spd, adr, drops);
        testsRun++;
        if (cnt != 1 || spd != 180 || drops != 0) begin
            testsFailed++;
            $display("[TB] FAIL same_cycle_new: count %0d speed %0d drops %0d, required 1 180 0", cnt, spd, drops);
        end
    endtask

    task automatic test_drop();
        int lat, cnt, spd, adr, drops;
        pulse(1'b0, 0, 1'b1, 7);
        testsRun++;
        if (bus.o_drop !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL drop_pulse: got %b, required 1", bus.o_drop);
        end
        @(negedge clk);
        testsRun++;
        if (bus.o_drop !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL drop_width: got %b, required 0", bus.o_drop);
        end
        waitWen(NW + 4, lat, cnt, spd, adr, drops);
        testsRun++;
        if (cnt != 0) begin
            testsFailed++;
            $display("[TB] FAIL drop_nowen: wen count %0d, required 0", cnt);
        end
    endtask

    task automatic test_busy_drop();
        int lat, cnt, spd, adr, drops;
        waitTs(4000);
        pulse(1'b1, 9, 1'b0, 0);
        waitTs(4010);
        pulse(1'b1, 10, 1'b0, 0);
        waitTs(4400);
        pulse(1'b0, 0, 1'b1, 9);
        @(negedge clk);
        pulse(1'b0, 0, 1'b1, 10);
        testsRun++;
        if (bus.o_drop !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL busy_drop: got %b, required 1", bus.o_drop);
        end
        waitWen(NW + 4, lat, cnt, spd, adr, drops);
        testsRun++;
        if (lat != NW - 1 || cnt != 1 || spd != 90 || adr != 9) begin
            testsFailed++;
            $display("[TB] FAIL busy_first: latency %0d count %0d speed %0d addr %0d, required %0d 1 90 9",
                     lat, cnt, spd, adr, NW - 1);
        end
        waitTs(4610);
        pulse(1'b0, 0, 1'b1, 10);
        waitWen(NW + 4, lat, cnt, spd, adr, drops);
        testsRun++;
        if (cnt != 1 || spd != 60 || adr != 10) begin
            testsFailed++;
            $display("[TB] FAIL busy_retry: count %0d speed %0d addr %0d, required 1 60 10", cnt, spd, adr);
        end
    endtask

    task automatic test_wrap();
        int lat, cnt, spd, adr, drops;
        waitTs(65500);
        pulse(1'b1, 3, 1'b0, 0);
        waitTs(164);
        pulse(1'b0, 0, 1'b1, 3);
        waitWen(NW + 4, lat, cnt, spd, adr, drops);
        testsRun++;
        if (lat != NW + 1 || spd != 180 || adr != 3) begin
            testsFailed++;
            $display("[TB] FAIL wrap: latency %0d speed %0d addr %0d, required %0d 180 3", lat, spd, adr, NW + 1);
        end
    endtask

    task automatic test_saturation();
        int lat, cnt, spd, adr, drops;
        waitTs(300);
        pulse(1'b1, 4, 1'b0, 0);
        waitTs(400);
        pulse(1'b0, 0, 1'b1, 4);
        waitWen(NW + 4, lat, cnt, spd, adr, drops);
        testsRun++;
        if (cnt != 1 || spd != ExpSat100 || adr != 4) begin
            testsFailed++;
            $display("[TB] FAIL quotient_360: count %0d speed %0d addr %0d, required 1 %0d 4",
                     cnt, spd, adr, ExpSat100);
        end
    endtask

    task automatic test_reset_mid_div();
        int lat, cnt, spd, adr, drops;
        waitTs(600);
        pulse(1'b1, 21, 1'b0, 0);
        waitTs(700);
        pulse(1'b1, 20, 1'b0, 0);
        waitTs(800);
        pulse(1'b0, 0, 1'b1, 20);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        testsRun++;
        if (bus.o_speed !== 8'd0 || bus.o_addr_speed !== 6'd0 || bus.o_wen !== 1'b0 ||
            bus.o_drop !== 1'b0 || bus.o_exit_ready !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL abort_outputs: speed %0d addr %0d wen %b drop %b ready %b, required 0 0 0 0 1",
                     bus.o_speed, bus.o_addr_speed, bus.o_wen, bus.o_drop, bus.o_exit_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        waitWen(NW + 4, lat, cnt, spd, adr, drops);
        testsRun++;
        if (cnt != 0) begin
            testsFailed++;
            $display("[TB] FAIL abort_nowen: wen count %0d, required 0", cnt);
        end
        pulse(1'b0, 0, 1'b1, 21);
        testsRun++;
        if (bus.o_drop !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL abort_valid21: drop %b, required 1", bus.o_drop);
        end
        pulse(1'b0, 0, 1'b1, 20);
        testsRun++;
        if (bus.o_drop !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL abort_valid20: drop %b, required 1", bus.o_drop);
        end
        waitWen(NW + 4, lat, cnt, spd, adr, drops);
        testsRun++;
        if (cnt != 0) begin
            testsFailed++;
            $display("[TB] FAIL abort_exit_nowen: wen count %0d, required 0", cnt);
        end
    endtask

    initial begin
        bus.i_tick        = 1'b1;
        bus.i_entry_valid = 1'b0;
        bus.i_entry_id    = '0;
        bus.i_exit_valid  = 1'b0;
        bus.i_exit_id     = '0;
        test_reset();
        test_basic();
        test_zero_elapsed();
        test_same_cycle();
        test_drop();
        test_busy_drop();
        test_wrap();
        test_saturation();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/speed_calc.md
SPEED_CALC -- requirements
Module: speed_calc

Interface
REQ-001 Parameter width, default 8: speed output width in bits.
REQ-002 Parameter depth, default 6: object-ID width; the table holds 2**depth entries.
REQ-003 Parameter TW, default 16: timestamp counter width.
REQ-004 Parameter NW, default 24: numerator and quotient width.
REQ-005 Parameter DIST_K, default 36000: distance/scale numerator constant, less than 2**NW.
REQ-006 clk  in  1  single clock; all logic on posedge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 i_tick  in  1  timebase strobe; the timestamp increments on each clk edge where i_tick=1.
REQ-009 i_entry_valid  in  1  object crossed the entry line.
REQ-010 i_entry_id  in  depth  ID of the entering object.
REQ-011 i_exit_valid  in  1  object crossed the exit line.
REQ-012 i_exit_id  in  depth  ID of the exiting object.
REQ-013 o_exit_ready  out  1  high when an exit event can be accepted (FSM in IDLE).
REQ-014 o_speed  out  width  computed speed; feeds the speed memory write data.
REQ-015 o_addr_speed  out  depth  ID of the result; feeds the speed memory write address.
REQ-016 o_wen  out  1  one-cycle write strobe to the speed memory.
REQ-017 o_drop  out  1  one-cycle pulse when an exit event is discarded.

Function
REQ-018 The timestamp counter shall be TW bits, free-running, and wrap from 2**TW-1 to 0.
REQ-019 On i_entry_valid, table[i_entry_id] shall store the current timestamp and set the entry's valid bit, overwriting any previous entry.
REQ-020 An exit shall be accepted when i_exit_valid=1, o_exit_ready=1 and the valid bit of i_exit_id is set.
- On acceptance, elapsed=(now-start) mod 2**TW is latched.
- The ID is latched.
- The valid bit is cleared.
- The FSM moves IDLE->DIV.
REQ-021 An exit with the valid bit clear, or with o_exit_ready=0, shall produce no write and shall pulse o_drop on the next cycle.
REQ-022 An elapsed value of 0 shall be treated as 1.
REQ-023 In DIV, a restoring divider shall compute DIST_K/elapsed at one quotient bit per cycle for exactly NW cycles, then move to DONE.
REQ-024 In DONE, for exactly one cycle, the block shall assert o_wen and drive o_speed and o_addr_speed, then return to IDLE.
- o_wen rises NW+1 clocks after the accepting edge.
REQ-025 o_speed and o_addr_speed shall hold their last values when o_wen=0.
REQ-026 An entry and an exit on the same ID in the same cycle shall be handled as follows:
- The exit uses the old start value.
- The entry then writes the new start and leaves the valid bit set.
REQ-027 Entries shall be accepted in every FSM state, including DIV and DONE.
REQ-028 o_exit_ready shall be 1 only in IDLE.

Reset
REQ-029 While rst_n=0, the following shall be cleared:
- The timestamp, all valid bits and the FSM (forced to IDLE).
- o_speed, o_addr_speed, o_wen and o_drop, all set to 0.
- o_exit_ready set to 1 after reset.
REQ-030 Reset asserted during DIV shall abort the division; no o_wen shall follow.

Configuration
REQ-031 Macro SPEED_SAT_EN: when defined, a quotient above 2**width-1 shall drive o_speed=2**width-1; when undefined, o_speed shall be the low width bits of the quotient.

Verification
REQ-032 Entry id 5 at ts 1000, exit id 5 at ts 1400 -> o_wen once, o_addr_speed=5, o_speed=90, NW+1 clocks after the exit.
REQ-033 Entry id 3 at ts 65500, exit at ts 164 (wrap) -> elapsed 200, o_speed=180.
REQ-034 Elapsed 100 -> quotient 360 -> o_speed=255 with SPEED_SAT_EN, o_speed=104 without.
REQ-035 Exit id 7 with no prior entry -> o_drop pulse, no o_wen; second exit during DIV -> o_drop pulse, first result unaffected.
REQ-036 rst_n low mid-DIV -> outputs 0, no o_wen after release, all valid bits clear.
